aux_ext80_card: RTL and testbench
=================================

# aux_ext80_card

Responder end of the Apple IIe auxiliary slot: models an Extended 80-Column Card (64 KiB aux RAM) driven by the aux-slot signals the FujiIIe motherboard produces. It decodes the multiplexed RAS/CAS address on `aux_ra`, and serves three cycle types from an external synchronous RAM port:
- CPU reads, returned on `aux_md`;
- CPU writes, taken from `aux_md`;
- video fetches, returned on `aux_vid`.

It sits beside `FujiIIe` in a target top level, clocked from the same 14.318 MHz domain.

## Interface
Parameters:
- `RAM_LATENCY`, default 1: cycles from `ram_en` to valid `ram_rdata`. Legal values are 1 and 2.
- `COUNT_WIDTH`, default 16: width of the RAS-only (refresh) cycle counter.

Ports:
- `clk_14M`  in  1  sole clock; all aux-slot inputs are synchronous to it.
- `reset`  in  1  synchronous, active-high reset.
- `aux_pras_n`  in  1  row address strobe.
- `aux_pcas_n`  in  1  column address strobe.
- `aux_ra`  in  8  multiplexed row/column address.
- `aux_clk_phi_0`  in  1  high = CPU half-cycle, low = video half-cycle.
- `aux_en80_n`  in  1  low = CPU access targets the card.
- `aux_rw80_n`  in  1  low = CPU write.
- `aux_md_in`  in  8  data from motherboard.
- `aux_md_out`  out  8  read data to motherboard.
- `aux_md_oe`  out  1  drive enable for `aux_md_out`.
- `aux_vid`  out  8  video byte.
- `ram_en`  out  1  RAM access strobe.
- `ram_we`  out  1  RAM write strobe.
- `ram_addr`  out  16  {row, col}.
- `ram_wdata`  out  8  write data.
- `ram_rdata`  in  8  read data.
- `ras_only_count`  out  COUNT_WIDTH  number of RAS-only cycles seen.

## Operation
- Strobe edges are detected against a registered copy of each strobe.
  - A "fall in cycle N" means the signal is sampled 0 at edge N and was 1 at edge N-1.
  - The same rule applies to rises.
- States: IDLE, ROW, RD, RD_WAIT, RD_HOLD, WR, HOLD.
- IDLE
  - On a `aux_pras_n` fall: latch `row <= aux_ra` and go to ROW.
  - A `aux_pcas_n` fall in IDLE (CAS-before-RAS) is ignored.
- ROW
  - On a `aux_pras_n` rise: increment `ras_only_count` (wraps at 2^COUNT_WIDTH) and go to IDLE.
  - On a `aux_pcas_n` fall: latch `col <= aux_ra`, then classify using inputs sampled in the same cycle:
    - phi_0=0: video read, go to RD.
    - phi_0=1, en80_n=0, rw80_n=1: CPU read, go to RD.
    - phi_0=1, en80_n=0, rw80_n=0: CPU write; capture `aux_md_in` into `ram_wdata` and go to WR.
    - phi_0=1, en80_n=1: not selected, go to HOLD.
- RD: `ram_en`=1 for one cycle, then RD_WAIT for RAM_LATENCY cycles.
- On data valid:
  - A video read loads `aux_vid <= ram_rdata`.
  - A CPU read loads `aux_md_out <= ram_rdata` and sets `aux_md_oe`=1.
  - Then go to RD_HOLD.
- RD_HOLD: on a `aux_pcas_n` rise, clear `aux_md_oe` and go to HOLD.
- WR: `ram_en`=`ram_we`=1 for exactly one cycle, then go to HOLD.
- HOLD: on a `aux_pras_n` rise, go to IDLE.
- From ROW/RD/RD_WAIT/RD_HOLD/HOLD, a `aux_pras_n` rise forces IDLE and clears `aux_md_oe`.
  - An aborted read leaves `aux_vid` and `aux_md_out` unchanged.
  - A write is never aborted: WR always completes its one cycle.
- If `aux_pras_n` and `aux_pcas_n` fall in the same cycle, only the row is latched; that CAS fall is ignored.
- `aux_vid` holds its value between video cycles.

## Timing
- Reset values:
  - state=IDLE.
  - `aux_md_out`=0, `aux_md_oe`=0, `aux_vid`=0.
  - `ram_en`=0, `ram_we`=0, `ram_addr`=0, `ram_wdata`=0.
  - `ras_only_count`=0.
  - Strobe history registers=1.
- Reset mid-access aborts immediately. No `ram_we` is issued in any cycle where `reset`=1.
- All outputs are registered.
- CAS fall in cycle N:
  - `ram_en`/`ram_addr` are valid in cycle N+1.
  - `ram_rdata` is sampled at cycle N+1+RAM_LATENCY.
  - `aux_md_out`/`aux_md_oe`/`aux_vid` are visible at N+2+RAM_LATENCY.
- Write: `ram_we` is high in cycle N+1, with `ram_wdata` = `aux_md_in` sampled at edge N.
- A CAS rise in cycle M gives `aux_md_oe`=0 at M+1.

## Structure
- Package `fuji_iie_aux_pkg` holds:
  - the state enum;
  - the access-class enum (VIDEO, CPU_RD, CPU_WR, NONE);
  - `AUX_ADDR_WIDTH`=16 and `AUX_RA_WIDTH`=8.
- One sub-module, `aux_strobe_edge`:
  - a registered history with rise/fall outputs, instantiated for each of `aux_pras_n` and `aux_pcas_n`;
  - it resets to 1.

## Test plan
- Video read:
  - Stimulus: RAS fall with ra=0x12, CAS fall with ra=0x34, phi_0=0, RAM preloaded 0x1234=0xA5.
  - Response: `ram_addr`=0x1234 with `ram_en` at N+1; `aux_vid`=0xA5 at N+3; `aux_md_oe` stays 0.
- CPU read:
  - Stimulus: phi_0=1, en80_n=0, rw80_n=1, address 0x0400=0x5A.
  - Response: `aux_md_out`=0x5A and `aux_md_oe`=1 from N+3 until one cycle after the CAS rise.
- CPU write:
  - Stimulus: address 0xBFFF, md_in=0x3C, rw80_n=0.
  - Response: exactly one cycle of `ram_we`=1 with `ram_addr`=0xBFFF and `ram_wdata`=0x3C; a subsequent read returns 0x3C.
- Unselected access and RAS-only refresh:
  - Stimulus: CPU cycle with en80_n=1, then 3 RAS-only cycles.
  - Response: no `ram_en` at any point; `ras_only_count`=3.
  - Count wrap: with COUNT_WIDTH=4, 17 RAS-only cycles give a count of 1.
- Aborts and reset:
  - Stimulus 1: RAS rise one cycle after a read's CAS fall.
  - Response 1: `aux_md_oe` never asserts and `aux_vid` is unchanged.
  - Stimulus 2: `reset` asserted in the WR cycle.
  - Response 2: `ram_we`=0 and all outputs return to their reset values next cycle.
- RAM_LATENCY=2 and simultaneous strobes:
  - Response 1: read data is visible at N+4.
  - Stimulus 2: RAS and CAS fall in the same cycle.
  - Response 2: row latched, no access issued until a later CAS fall.

Source files
------------

// File: rtl/fuji_iie_aux_pkg.sv
// fuji_iie_aux_pkg: shared types and widths for the aux-slot 80-column card
package fuji_iie_aux_pkg;
  localparam int AUX_ADDR_WIDTH = 16;
  localparam int AUX_RA_WIDTH = 8;
  typedef enum logic [2:0] {IDLE, ROW, RD, RD_WAIT, RD_HOLD, WR, HOLD} aux_state_t;
  typedef enum logic [1:0] {VIDEO, CPU_RD, CPU_WR, NONE} aux_acc_t;
  function automatic aux_acc_t classify(input logic phi_0, input logic en80_n, input logic rw80_n);
    return !phi_0 ? VIDEO : en80_n ? NONE : rw80_n ? CPU_RD : CPU_WR;
  endfunction
endpackage

// File: rtl/aux_strobe_edge.sv
// aux_strobe_edge: registered strobe history with rise/fall detection
module aux_strobe_edge (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise,
  output logic fall
);
  logic q;
  always_ff @(posedge clk) q <= rst ? 1'b1 : d;
  assign rise = d & ~q;
  assign fall = ~d & q;
endmodule

// File: rtl/aux_ext80_card.sv
// aux_ext80_card: Apple IIe extended 80-column card responder on the aux slot
module aux_ext80_card
  import fuji_iie_aux_pkg::*;
#(
  parameter int RAM_LATENCY = 1,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                      clk_14M,
  input  logic                      reset,
  input  logic                      aux_pras_n,
  input  logic                      aux_pcas_n,
  input  logic [AUX_RA_WIDTH-1:0]   aux_ra,
  input  logic                      aux_clk_phi_0,
  input  logic                      aux_en80_n,
  input  logic                      aux_rw80_n,
  input  logic [7:0]                aux_md_in,
  output logic [7:0]                aux_md_out,
  output logic                      aux_md_oe,
  output logic [7:0]                aux_vid,
  output logic                      ram_en,
  output logic                      ram_we,
  output logic [AUX_ADDR_WIDTH-1:0] ram_addr,
  output logic [7:0]                ram_wdata,
  input  logic [7:0]                ram_rdata,
  output logic [COUNT_WIDTH-1:0]    ras_only_count
);
  logic pras_rise, pras_fall, pcas_rise, pcas_fall;
  logic wait_cnt, wait_done, we_q, cas_hit, data_hit;
  logic [AUX_RA_WIDTH-1:0] row;
  aux_state_t state, state_d;
  aux_acc_t acc, cls;
  aux_strobe_edge u_ras (.clk(clk_14M), .rst(reset), .d(aux_pras_n), .rise(pras_rise), .fall(pras_fall));
  aux_strobe_edge u_cas (.clk(clk_14M), .rst(reset), .d(aux_pcas_n), .rise(pcas_rise), .fall(pcas_fall));
  assign cls = classify(aux_clk_phi_0, aux_en80_n, aux_rw80_n);
  assign wait_done = wait_cnt == 1'(RAM_LATENCY - 1);
  assign cas_hit = state == ROW && !pras_rise && pcas_fall;
  assign data_hit = state == RD_WAIT && !pras_rise && wait_done;
  assign ram_we = we_q & ~reset;
  always_ff @(posedge clk_14M) state <= reset ? IDLE : state_d;
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    state_d = pras_fall ? ROW : IDLE;
      ROW:     state_d = pras_rise ? IDLE : !pcas_fall ? ROW : cls == CPU_WR ? WR : cls == NONE ? HOLD : RD;
      RD:      state_d = pras_rise ? IDLE : RD_WAIT;
      RD_WAIT: state_d = pras_rise ? IDLE : wait_done ? RD_HOLD : RD_WAIT;
      RD_HOLD: state_d = pras_rise ? IDLE : pcas_rise ? HOLD : RD_HOLD;
      WR:      state_d = pras_rise ? IDLE : HOLD;
      HOLD:    state_d = pras_rise ? IDLE : HOLD;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_14M) begin
    if (reset) begin
      aux_md_out <= '0;
      aux_md_oe <= 1'b0;
      aux_vid <= '0;
      ram_en <= 1'b0;
      we_q <= 1'b0;
      ram_addr <= '0;
      ram_wdata <= '0;
      ras_only_count <= '0;
      row <= '0;
      acc <= NONE;
      wait_cnt <= 1'b0;
    end else begin
      ram_en <= cas_hit && cls != NONE;
      we_q <= cas_hit && cls == CPU_WR;
      wait_cnt <= state == RD_WAIT ? wait_cnt + 1'b1 : 1'b0;
      if (state == IDLE && pras_fall) row <= aux_ra;
      if (state == ROW && pras_rise) ras_only_count <= ras_only_count + 1'b1;
      if (cas_hit) begin
        acc <= cls;
        ram_addr <= {row, aux_ra};
        ram_wdata <= cls == CPU_WR ? aux_md_in : ram_wdata;
      end
      if (data_hit && acc == VIDEO) aux_vid <= ram_rdata;
      if (data_hit && acc == CPU_RD) aux_md_out <= ram_rdata;
      aux_md_oe <= (data_hit && acc == CPU_RD) || (aux_md_oe && !pras_rise && !(state == RD_HOLD && pcas_rise));
    end
  end
endmodule

// File: tb/tb_aux_ext80_card.sv
// tb_aux_ext80_card: directed and randomized bus cycles against a memory-array reference model
module tb_aux_ext80_card;
  localparam int K_VID = 0, K_RD = 1, K_WR = 2, K_NONE = 3;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset, pras_n, pcas_n, phi0, en80_n, rw80_n;
  logic [7:0] ra, md_in;
  logic [7:0] md_out1, vid1, wdata1, rdata1, md_out2, vid2, wdata2, rdata2, st2;
  logic oe1, en1, we1, oe2, en2, we2;
  logic [15:0] addr1, addr2, cnt1;
  logic [3:0] cnt2;
  logic ld;
  logic [15:0] ld_a;
  logic [7:0] ld_d;
  bit [7:0] mem1 [65536];
  bit [7:0] mem2 [65536];
  bit [7:0] ref_mem [65536];
  logic [15:0] pool [16];
  logic [7:0] exp_vid;
  int exp_cnt, checks, errors;

  aux_ext80_card dut1 (
    .clk_14M(clk), .reset(reset), .aux_pras_n(pras_n), .aux_pcas_n(pcas_n), .aux_ra(ra),
    .aux_clk_phi_0(phi0), .aux_en80_n(en80_n), .aux_rw80_n(rw80_n), .aux_md_in(md_in),
    .aux_md_out(md_out1), .aux_md_oe(oe1), .aux_vid(vid1), .ram_en(en1), .ram_we(we1),
    .ram_addr(addr1), .ram_wdata(wdata1), .ram_rdata(rdata1), .ras_only_count(cnt1)
  );
  aux_ext80_card #(.RAM_LATENCY(2), .COUNT_WIDTH(4)) dut2 (
    .clk_14M(clk), .reset(reset), .aux_pras_n(pras_n), .aux_pcas_n(pcas_n), .aux_ra(ra),
    .aux_clk_phi_0(phi0), .aux_en80_n(en80_n), .aux_rw80_n(rw80_n), .aux_md_in(md_in),
    .aux_md_out(md_out2), .aux_md_oe(oe2), .aux_vid(vid2), .ram_en(en2), .ram_we(we2),
    .ram_addr(addr2), .ram_wdata(wdata2), .ram_rdata(rdata2), .ras_only_count(cnt2)
  );

  always @(posedge clk) begin
    if (ld) mem1[ld_a] <= ld_d;
    else if (en1 && we1) mem1[addr1] <= wdata1;
    if (en1) rdata1 <= mem1[addr1];
  end
  always @(posedge clk) begin
    if (ld) mem2[ld_a] <= ld_d;
    else if (en2 && we2) mem2[addr2] <= wdata2;
    if (en2) st2 <= mem2[addr2];
    rdata2 <= st2;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [15:0] a, input logic [7:0] d);
    ld = 1'b1; ld_a = a; ld_d = d;
    tick;
    ld = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic set_kind(input int k);
    phi0 = k != K_VID;
    en80_n = k == K_VID ? 1'($urandom_range(0, 1)) : k == K_NONE;
    rw80_n = k == K_VID ? 1'($urandom_range(0, 1)) : k != K_WR;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_md_out1"}, md_out1, 0); chk({tag, "_oe1"}, oe1, 0); chk({tag, "_vid1"}, vid1, 0);
    chk({tag, "_en1"}, en1, 0); chk({tag, "_we1"}, we1, 0); chk({tag, "_addr1"}, addr1, 0);
    chk({tag, "_wdata1"}, wdata1, 0); chk({tag, "_cnt1"}, cnt1, 0);
    chk({tag, "_vid2"}, vid2, 0); chk({tag, "_oe2"}, oe2, 0); chk({tag, "_we2"}, we2, 0);
    chk({tag, "_cnt2"}, cnt2, 0);
  endtask

  task automatic check_count;
    chk("cnt1", cnt1, exp_cnt & 'hFFFF);
    chk("cnt2", cnt2, exp_cnt & 'hF);
  endtask

  task automatic access(input int k, input logic [15:0] a, input logic [7:0] d, input bit both_fall);
    set_kind(k);
    md_in = d;
    ra = a[15:8];
    pras_n = 1'b0;
    if (both_fall) begin
      pcas_n = 1'b0;
      tick;
      chk("simul_en1", en1, 0); chk("simul_en2", en2, 0);
      ra = $urandom;
      tick;
      chk("simul_en1_b", en1, 0);
      pcas_n = 1'b1;
      tick;
      chk("simul_en1_c", en1, 0);
    end else tick;
    ra = a[7:0];
    pcas_n = 1'b0;
    tick;
    ra = $urandom;
    md_in = $urandom;
    if (k == K_NONE) begin
      chk("nosel_en1", en1, 0); chk("nosel_en2", en2, 0);
    end else begin
      chk("en1", en1, 1); chk("addr1", addr1, a); chk("we1", we1, k == K_WR);
      chk("en2", en2, 1); chk("addr2", addr2, a);
      if (k == K_WR) begin
        chk("wdata1", wdata1, d); chk("wdata2", wdata2, d);
      end
    end
    tick;
    chk("en1_pulse", en1, 0); chk("we1_pulse", we1, 0); chk("en2_pulse", en2, 0);
    if (k == K_WR) ref_mem[a] = d;
    tick;
    if (k == K_VID) begin
      exp_vid = ref_mem[a];
      chk("vid1", vid1, exp_vid); chk("vid_oe1", oe1, 0);
    end
    if (k == K_RD) begin
      chk("md_out1", md_out1, ref_mem[a]); chk("oe1", oe1, 1); chk("oe2_early", oe2, 0);
      chk("rd_vid1_hold", vid1, exp_vid);
    end
    tick;
    if (k == K_VID) begin
      chk("vid2", vid2, exp_vid); chk("vid_oe2", oe2, 0);
    end
    if (k == K_RD) begin
      chk("md_out2", md_out2, ref_mem[a]); chk("oe2", oe2, 1);
    end
    tick;
    if (k == K_RD) chk("oe1_held", oe1, 1);
    pcas_n = 1'b1;
    tick;
    chk("oe1_cas_rise", oe1, 0); chk("oe2_cas_rise", oe2, 0);
    pras_n = 1'b1;
    tick;
    tick;
  endtask

  task automatic refresh;
    ra = $urandom;
    pras_n = 1'b0;
    tick;
    chk("ref_en1", en1, 0); chk("ref_en2", en2, 0);
    pras_n = 1'b1;
    tick;
    exp_cnt++;
    tick;
  endtask

  task automatic abort_read(input int k, input logic [15:0] a);
    set_kind(k);
    ra = a[15:8];
    pras_n = 1'b0;
    tick;
    ra = a[7:0];
    pcas_n = 1'b0;
    tick;
    pras_n = 1'b1;
    tick;
    pcas_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("abort_oe1", oe1, 0); chk("abort_oe2", oe2, 0);
      chk("abort_vid1", vid1, exp_vid); chk("abort_vid2", vid2, exp_vid);
      tick;
    end
  endtask

  initial begin
    logic [15:0] a;
    checks = 0; errors = 0; exp_cnt = 0; exp_vid = 8'h00;
    reset = 1'b1; pras_n = 1'b1; pcas_n = 1'b1; ra = '0; phi0 = 1'b1;
    en80_n = 1'b1; rw80_n = 1'b1; md_in = '0; ld = 1'b0; ld_a = '0; ld_d = '0;
    repeat (3) tick;
    check_reset_vals("rst");
    reset = 1'b0;
    tick;
    check_reset_vals("post_rst");
    preload(16'h1234, 8'hA5);
    preload(16'h0400, 8'h5A);
    for (int i = 0; i < 16; i++) begin
      pool[i] = 16'($urandom);
      preload(pool[i], 8'($urandom));
    end

    access(K_VID, 16'h1234, 8'h00, 0);
    chk("plan_vid", vid1, 8'hA5);
    access(K_RD, 16'h0400, 8'h00, 0);
    chk("plan_rd", md_out1, 8'h5A);
    access(K_WR, 16'hBFFF, 8'h3C, 0);
    access(K_RD, 16'hBFFF, 8'h00, 0);
    chk("plan_wr_readback", md_out1, 8'h3C);
    access(K_NONE, 16'h2222, 8'h77, 0);
    repeat (3) refresh;
    check_count;
    chk("plan_cnt3", cnt1, 3);

    abort_read(K_VID, pool[0]);
    abort_read(K_RD, pool[1]);
    check_count;

    access(K_VID, pool[2], 8'h00, 1);

    for (int i = 0; i < 40; i++) begin
      int k;
      k = $urandom_range(0, 4);
      if (k == 4) refresh;
      else access(k, pool[$urandom_range(0, 15)], 8'($urandom), 0);
    end
    check_count;

    a = pool[3];
    set_kind(K_WR);
    md_in = ~ref_mem[a];
    ra = a[15:8];
    pras_n = 1'b0;
    tick;
    ra = a[7:0];
    pcas_n = 1'b0;
    tick;
    chk("wr_we_before_rst", we1, 1);
    reset = 1'b1;
    pras_n = 1'b1;
    pcas_n = 1'b1;
    #1;
    chk("rst_we1_gated", we1, 0); chk("rst_we2_gated", we2, 0);
    tick;
    check_reset_vals("wr_rst");
    exp_cnt = 0; exp_vid = 8'h00;
    reset = 1'b0;
    tick;
    access(K_RD, a, 8'h00, 0);

    repeat (17) refresh;
    check_count;
    chk("wrap_cnt2", cnt2, 1);
    chk("wrap_cnt1", cnt1, 17);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
